apb_ecc_reg_file: RTL and testbench

- Parametrised APB3 slave register file for the ECC accelerator. Successor to the fixed 4-register bank.
- Provides NUM_REGS writable configuration registers plus one read-only STATUS register.
- Implements the full APB SETUP/ACCESS handshake, with PREADY and PSLVERR.
- Generates a one-cycle start pulse to the ECC core, locks configuration while the core is busy, and keeps a sticky done flag.

---
 rtl/apb_ecc_reg_file_if.sv | 38 +++
 rtl/apb_ecc_reg_file.sv | 151 +++++++++++++++
 tb/tb_apb_ecc_reg_file.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_ecc_reg_file_if.sv
// APB3 bus bundle for the ECC register file.
// Optional byte-strobe lane PSTRB is present when APB_PSTRB_EN is defined.
interface apb_ecc_reg_file_if #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
`ifdef APB_PSTRB_EN
    logic [AMBA_WORD/8-1:0]     PSTRB;
`endif
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

`ifdef APB_PSTRB_EN
    modport master (
        output PADDR, PWDATA, PSEL, PENABLE, PWRITE, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PADDR, PWDATA, PSEL, PENABLE, PWRITE, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
`else
    modport master (
        output PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        output PRDATA, PREADY, PSLVERR
    );
`endif
endinterface

// File: rtl/apb_ecc_reg_file.sv
// APB3 slave register file for the ECC accelerator: NUM_REGS config registers,
// a read-only STATUS word at index NUM_REGS, a start pulse on CTRL writes,
// write lock while the core is busy and a sticky done flag.
// Optional feature macro: APB_PSTRB_EN (byte-lane write strobes).
module apb_ecc_reg_file #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned NUM_REGS        = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    apb_ecc_reg_file_if.slave             apb,
    output logic [NUM_REGS*AMBA_WORD-1:0] regs_flat,
    output logic                          ctrl_start,
    input  logic                          core_busy,
    input  logic                          core_done
);
    localparam int unsigned IDX_W  = AMBA_ADDR_WIDTH - 2;
    localparam int unsigned STRB_W = AMBA_WORD / 8;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e               state_q, state_d;
    logic [AMBA_WORD-1:0] regs_q [NUM_REGS];
    logic [AMBA_WORD-1:0] prdata_q, prdata_d;
    logic                 pready_q, pready_d;
    logic                 pslverr_q, pslverr_d;
    logic                 ctrl_start_q, ctrl_start_d;
    logic                 done_q, done_d;

    logic [IDX_W-1:0]     idx_c;
    logic                 addr_ok_c, is_status_c, access_c;
    logic                 commit_c, clr_done_c, busy_err_c;
    logic [STRB_W-1:0]    strb_c;
    logic [AMBA_WORD-1:0] status_c, rdata_c;

    // Address decode; the bus holds address/data stable for the whole transfer.
    assign idx_c       = apb.PADDR[AMBA_ADDR_WIDTH-1:2];
    assign addr_ok_c   = (apb.PADDR[1:0] == 2'b00) && (idx_c <= STATUS_IDX);
    assign is_status_c = (idx_c == STATUS_IDX);
    assign access_c    = (state_q == ACCESS) && apb.PSEL && apb.PENABLE;

`ifdef APB_PSTRB_EN
    assign strb_c = apb.PSTRB;
`else
    assign strb_c = '1;
`endif

    // core_busy is judged at the commit edge, so it also feeds PSLVERR live in ACCESS.
    assign commit_c   = access_c && apb.PWRITE && addr_ok_c && !is_status_c && !core_busy;
    assign busy_err_c = access_c && apb.PWRITE && addr_ok_c && !is_status_c && core_busy;
    assign clr_done_c = access_c && !apb.PWRITE && addr_ok_c && is_status_c;

    // STATUS word assembly.
    always_comb begin
        status_c      = '0;
        status_c[0]   = core_busy;
        status_c[1]   = done_q;
        status_c[9:2] = 8'(NUM_REGS);
    end

    // Read data mux; invalid addresses read as zero.
    always_comb begin
        rdata_c = '0;
        if (addr_ok_c) begin
            if (is_status_c) begin
                rdata_c = status_c;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx_c == IDX_W'(i)) rdata_c = regs_q[i];
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (apb.PSEL && !apb.PENABLE) state_d = SETUP;
            SETUP:   state_d = apb.PSEL ? ACCESS : IDLE;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered bus and sideband outputs.
    always_comb begin
        prdata_d     = prdata_q;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        ctrl_start_d = 1'b0;
        done_d       = done_q;
        if (state_q == SETUP && state_d == ACCESS) begin
            pready_d  = 1'b1;
            pslverr_d = !addr_ok_c || (apb.PWRITE && is_status_c);
            if (!apb.PWRITE) prdata_d = rdata_c;
        end
        ctrl_start_d = commit_c && (idx_c == '0) && (|strb_c);
        if (clr_done_c) done_d = 1'b0;
        if (core_done)  done_d = 1'b1;
    end

    // Output and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            ctrl_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            prdata_q     <= prdata_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            ctrl_start_q <= ctrl_start_d;
            done_q       <= done_d;
        end
    end

    // Register bank, byte-lane writes on commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (commit_c) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_c == IDX_W'(i)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (strb_c[b]) regs_q[i][b*8 +: 8] <= apb.PWDATA[b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*AMBA_WORD +: AMBA_WORD] = regs_q[g];
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q | busy_err_c;
    assign ctrl_start  = ctrl_start_q;
endmodule

// File: tb/tb_apb_ecc_reg_file.sv
// Self-checking bench for apb_ecc_reg_file: vector table plus scoreboard queue,
// followed by hand-written sequences for busy timing, done_sticky, PSEL drop and reset.
module tb_apb_ecc_reg_file;
    localparam int unsigned W  = 32;
    localparam int unsigned AW = 20;
    localparam int unsigned NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*W-1:0]   regs_flat;
    logic              ctrl_start;
    logic              core_busy;
    logic              core_done;

    apb_ecc_reg_file_if #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW)) bus ();

    apb_ecc_reg_file #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .apb        (bus),
        .regs_flat  (regs_flat),
        .ctrl_start (ctrl_start),
        .core_busy  (core_busy),
        .core_done  (core_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [19:0] addr;
        logic [31:0] wdata;
        bit          busy;
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          exp_start;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        bit          chk_rd;
        bit          err;
        bit          start;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_xfer  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] rd, input bit chk_rd, input bit err, input bit start);
        exp_t e;
        e.rd = rd; e.chk_rd = chk_rd; e.err = err; e.start = start;
        sb.push_back(e);
    endtask

    // One full APB transfer; compares against the front of the scoreboard when PREADY shows.
    task automatic xfer(input bit wr, input logic [19:0] addr, input logic [31:0] wdata,
                        input bit busy_setup, input bit busy_acc, input bit done_acc);
        exp_t  e;
        int    cyc;
        logic  st0, st1;
        string tag;
        tag = $sformatf("xfer%0d", n_xfer);
        n_xfer++;
        @(posedge clk); #1;
        core_busy   = busy_setup;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wdata;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        cyc = 1;
        check({tag, "_wait_state"}, 128'(bus.PREADY), 128'(0));
        while (bus.PREADY !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_enable_cycles"}, 128'(cyc), 128'(2));
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 128'(1), 128'(0));
            e = '{rd: '0, chk_rd: 1'b0, err: 1'b0, start: 1'b0};
        end else begin
            e = sb.pop_front();
        end
        core_busy = busy_acc;
        core_done = done_acc;
        #1;
        check({tag, "_pslverr"}, 128'(bus.PSLVERR), 128'(e.err));
        if (e.chk_rd) check({tag, "_prdata"}, 128'(bus.PRDATA), 128'(e.rd));
        @(posedge clk); #1;
        core_busy   = 1'b0;
        core_done   = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        st0 = ctrl_start;
        @(posedge clk); #1;
        st1 = ctrl_start;
        check({tag, "_ctrl_start"}, 128'(st0), 128'(e.start));
        check({tag, "_ctrl_start_width"}, 128'(st1), 128'(0));
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        vecs[0]  = '{1'b1, 20'h00000, 32'h0000_00A5, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[1]  = '{1'b1, 20'h00008, 32'h0000_1234, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[2]  = '{1'b0, 20'h00008, 32'h0,         1'b0, 32'h0000_1234, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 20'h00004, 32'h0000_FFFF, 1'b1, 32'h0,         1'b1, 1'b0};
        vecs[4]  = '{1'b0, 20'h00004, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
        vecs[5]  = '{1'b1, 20'h00010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 1'b0};
        vecs[6]  = '{1'b1, 20'h00006, 32'h0000_0055, 1'b0, 32'h0,         1'b1, 1'b0};
        vecs[7]  = '{1'b0, 20'h00014, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
        vecs[8]  = '{1'b0, 20'h00010, 32'h0,         1'b0, 32'h0000_0010, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 20'h00010, 32'h0,         1'b1, 32'h0000_0011, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 20'h00000, 32'h0000_00A5, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[11] = '{1'b1, 20'h0000C, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[12] = '{1'b0, 20'h0000C, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0, 1'b0};

        reset       = 1'b0;
        core_busy   = 1'b0;
        core_done   = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
`ifdef APB_PSTRB_EN
        bus.PSTRB   = '1;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        check("reset_prdata",     128'(bus.PRDATA),  128'(0));
        check("reset_pready",     128'(bus.PREADY),  128'(0));
        check("reset_pslverr",    128'(bus.PSLVERR), 128'(0));
        check("reset_ctrl_start", 128'(ctrl_start),  128'(0));
        check("reset_regs_flat",  128'(regs_flat),   128'(0));

        for (int i = 0; i < 13; i++) begin
            push_exp(vecs[i].exp_rd, !vecs[i].wr, vecs[i].exp_err, vecs[i].exp_start);
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].busy, vecs[i].busy, 1'b0);
        end
        check("table_regs_flat", 128'(regs_flat),
              {32'hCAFE_F00D, 32'h0000_1234, 32'h0000_0000, 32'h0000_00A5});

        // core_busy rising in ACCESS blocks the write; falling in ACCESS lets it through.
        push_exp(32'h0, 1'b0, 1'b1, 1'b0);
        xfer(1'b1, 20'h00004, 32'h0000_0033, 1'b0, 1'b1, 1'b0);
        push_exp(32'h0, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 20'h00004, 32'h0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 20'h00004, 32'h0000_0044, 1'b1, 1'b0, 1'b0);
        push_exp(32'h0000_0044, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 20'h00004, 32'h0, 1'b0, 1'b0, 1'b0);

        // done_sticky set, read-clear, and set winning over a coincident clear.
        pulse_done();
        push_exp(32'h0000_0012, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h0000_0010, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b0);
        pulse_done();
        push_exp(32'h0000_0012, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b1);
        push_exp(32'h0000_0012, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h0000_0010, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b0);

        // PSEL dropped during SETUP: transfer abandoned, register 2 untouched.
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 20'h00008; bus.PWDATA = 32'h0000_0099;
        @(posedge clk); #1;
        bus.PSEL = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("psel_drop_pready", 128'(bus.PREADY), 128'(0));
        end
        check("psel_drop_reg2", 128'(regs_flat[2*W +: W]), 128'(32'h0000_1234));
        check("psel_drop_start", 128'(ctrl_start), 128'(0));

        // Reset asserted during a write to register 1.
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 20'h00004; bus.PWDATA = 32'h0000_0077;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        reset = 1'b0;
        #1;
        check("rst_mid_prdata",  128'(bus.PRDATA),  128'(0));
        check("rst_mid_pready",  128'(bus.PREADY),  128'(0));
        check("rst_mid_pslverr", 128'(bus.PSLVERR), 128'(0));
        check("rst_mid_start",   128'(ctrl_start),  128'(0));
        check("rst_mid_regs",    128'(regs_flat),   128'(0));
        @(posedge clk); @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_after_reg1",   128'(regs_flat[W +: W]), 128'(0));
        check("rst_after_pready", 128'(bus.PREADY), 128'(0));
        push_exp(32'h0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 20'h00004, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
        push_exp(32'h0000_0077, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 20'h00004, 32'h0, 1'b0, 1'b0, 1'b0);

        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
